// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host/UART side signal bundle for the UART transmit FIFO
interface uart_tx_fifo_if #(
  parameter int AW = 4
);
  // Host write side and UART handshake inputs
  logic          WR;
  logic [7:0]    WD;
  logic          READY;
  logic          CLR_ERR;

  // UART launch outputs and status
  logic          START;
  logic [7:0]    DATA;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   COUNT;
  logic          OVF;
  logic          TOERR;

  modport slave (
    input  WR, WD, READY, CLR_ERR,
    output START, DATA, FULL, EMPTY, COUNT, OVF, TOERR
  );

  modport master (
    output WR, WD, READY, CLR_ERR,
    input  START, DATA, FULL, EMPTY, COUNT, OVF, TOERR
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter through a start/ready handshake
module uart_tx_fifo #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_fifo_if.slave bus
);

  localparam int              TW      = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0]   TMO_C   = TW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          toerr_q, toerr_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          launch;
  logic          timeout_hit;

  // FULL is judged on the registered count, so a same-cycle pop never frees room for a write
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign push        = bus.WR && !full;
  // A launch only looks at stored bytes; a write landing this cycle cannot bypass to the UART
  assign launch      = (state_q == IDLE) && !empty && bus.READY;
  assign timeout_hit = (state_q == WAIT_ACK) && bus.READY && (tmr_q == TMO_C);

  // State register and all datapath flops
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mem_q   <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      toerr_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      start_q <= start_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      toerr_q <= toerr_d;
      tmr_q   <= tmr_d;
    end
  end

  // Launch handshake sequencing: launch, wait for the UART to go busy, wait for it to finish
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.READY)       state_d = WAIT_DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      WAIT_DONE: begin
        if (bus.READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage, pointers, count, launch outputs, ack timer and sticky error flags
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    start_d = 1'b0;
    data_d  = data_q;
    ovf_d   = ovf_q;
    toerr_d = toerr_q;
    tmr_d   = tmr_q;

    if (push) begin
      mem_d[wp_q] = bus.WD;
      wp_d        = wp_q + 1'b1;
    end

    if (launch) begin
      start_d = 1'b1;
      data_d  = mem_q[rp_q];
      rp_d    = rp_q + 1'b1;
      tmr_d   = '0;
    end else if ((state_q == WAIT_ACK) && bus.READY && !timeout_hit) begin
      tmr_d = tmr_q + 1'b1;
    end

    if (push && !launch)      count_d = count_q + 1'b1;
    else if (!push && launch) count_d = count_q - 1'b1;

    // A set event in the same cycle as a clear leaves the flag set
    if (bus.WR && full) ovf_d = 1'b1;
    else if (bus.CLR_ERR) ovf_d = 1'b0;

    if (timeout_hit) toerr_d = 1'b1;
    else if (bus.CLR_ERR) toerr_d = 1'b0;
  end

  assign bus.START = start_q;
  assign bus.DATA  = data_q;
  assign bus.FULL  = full;
  assign bus.EMPTY = empty;
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
  assign bus.TOERR = toerr_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_bytes [$];

  uart_tx_fifo_if #(.AW(4)) bus ();

  uart_tx_fifo #(.DEPTH(16), .AW(4), .ACK_TIMEOUT(1023)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n, input string tag);
    int waited;
    logic [7:0] want;
    for (int k = 0; k < n; k++) begin
      bus.READY = 1'b1;
      waited = 0;
      while (bus.START !== 1'b1 && waited < 50) begin
        tick();
        waited++;
      end
      want = exp_bytes.pop_front();
      n_tests++;
      if (bus.START !== 1'b1) begin
        n_fail++; $display("FAIL %s_launch%0d got no START within 50 cycles, want START=1", tag, k);
      end else if (bus.DATA !== want) begin
        n_fail++; $display("FAIL %s_byte%0d got %0h want %0h", tag, k, bus.DATA, want);
      end
      tick();
      bus.READY = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.WR = 1'b0; bus.WD = 8'h00; bus.READY = 1'b1; bus.CLR_ERR = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL reset_start got %0h want 0", bus.START); end
    n_tests++; if (bus.DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data got %0h want 0", bus.DATA); end
    n_tests++; if (bus.COUNT !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.COUNT); end
    n_tests++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0h want 1", bus.EMPTY); end
    n_tests++; if (bus.FULL !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0h want 0", bus.FULL); end
    n_tests++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0h want 0", bus.OVF); end
    n_tests++; if (bus.TOERR !== 1'b0) begin n_fail++; $display("FAIL reset_toerr got %0h want 0", bus.TOERR); end
  endtask

  task automatic test_single_byte();
    int extra;
    bus.READY = 1'b1;
    bus.WR = 1'b1; bus.WD = 8'h41;                 // cycle 0
    tick();                                        // cycle 1
    bus.WR = 1'b0;
    n_tests++; if (bus.COUNT !== 5'd1) begin n_fail++; $display("FAIL single_count1 got %0d want 1", bus.COUNT); end
    n_tests++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got START=%0h want 0", bus.START); end
    tick();                                        // cycle 2
    n_tests++; if (bus.START !== 1'b1) begin n_fail++; $display("FAIL single_start got %0h want 1", bus.START); end
    n_tests++; if (bus.DATA !== 8'h41) begin n_fail++; $display("FAIL single_data got %0h want 41", bus.DATA); end
    n_tests++; if (bus.COUNT !== 5'd0) begin n_fail++; $display("FAIL single_count0 got %0d want 0", bus.COUNT); end
    tick();                                        // cycle 3
    bus.READY = 1'b0;
    extra = 0;
    for (int c = 3; c < 20; c++) begin
      if (bus.START === 1'b1) extra++;
      tick();
    end
    bus.READY = 1'b1;                              // cycle 20
    for (int c = 0; c < 6; c++) begin
      if (bus.START === 1'b1) extra++;
      tick();
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL single_extra_start got %0d pulses want 0", extra); end
    n_tests++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0h want 1", bus.EMPTY); end
  endtask

  task automatic test_fill_overflow();
    int extra;
    bus.READY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.WR = 1'b1; bus.WD = 8'(i);
      tick();
      if (i == 14) begin
        n_tests++; if (bus.FULL !== 1'b0) begin n_fail++; $display("FAIL fill_full_at15 got %0h want 0", bus.FULL); end
      end
    end
    bus.WR = 1'b0;
    n_tests++; if (bus.COUNT !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d want 16", bus.COUNT); end
    n_tests++; if (bus.FULL !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0h want 1", bus.FULL); end
    n_tests++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got %0h want 1", bus.OVF); end
    n_tests++; if (bus.START !== 1'b0) begin n_fail++; $display("FAIL fill_no_start got %0h want 0", bus.START); end
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    n_tests++; if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_clr got %0h want 0", bus.OVF); end
    for (int i = 0; i < 16; i++) exp_bytes.push_back(8'(i));
    drain(16, "fill");
    bus.READY = 1'b1;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.START === 1'b1) extra++;
      tick();
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL fill_dropped_byte_sent got %0d pulses want 0", extra); end
    n_tests++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL fill_empty got %0h want 1", bus.EMPTY); end
  endtask

  task automatic test_simultaneous();
    bus.READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.WR = 1'b1; bus.WD = 8'h20 + 8'(i);
      tick();
    end
    bus.WR = 1'b0;
    n_tests++; if (bus.FULL !== 1'b1) begin n_fail++; $display("FAIL simul_full got %0h want 1", bus.FULL); end
    bus.READY = 1'b1; bus.WR = 1'b1; bus.WD = 8'h99;
    tick();
    bus.WR = 1'b0;
    n_tests++; if (bus.START !== 1'b1) begin n_fail++; $display("FAIL simul_full_start got %0h want 1", bus.START); end
    n_tests++; if (bus.DATA !== 8'h20) begin n_fail++; $display("FAIL simul_full_data got %0h want 20", bus.DATA); end
    n_tests++; if (bus.COUNT !== 5'd15) begin n_fail++; $display("FAIL simul_full_count got %0d want 15", bus.COUNT); end
    n_tests++; if (bus.OVF !== 1'b1) begin n_fail++; $display("FAIL simul_full_ovf got %0h want 1", bus.OVF); end
    tick();
    bus.READY = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 10; i++) exp_bytes.push_back(8'h20 + 8'(i));
    drain(10, "simul_a");
    n_tests++; if (bus.COUNT !== 5'd5) begin n_fail++; $display("FAIL simul_count5 got %0d want 5", bus.COUNT); end
    bus.READY = 1'b1;
    tick();
    bus.WR = 1'b1; bus.WD = 8'h77;
    tick();
    bus.WR = 1'b0;
    n_tests++; if (bus.START !== 1'b1) begin n_fail++; $display("FAIL simul_mid_start got %0h want 1", bus.START); end
    n_tests++; if (bus.DATA !== 8'h2B) begin n_fail++; $display("FAIL simul_mid_data got %0h want 2b", bus.DATA); end
    n_tests++; if (bus.COUNT !== 5'd5) begin n_fail++; $display("FAIL simul_mid_count got %0d want 5", bus.COUNT); end
    tick();
    bus.READY = 1'b0;
    tick(); tick();
    for (int i = 12; i < 16; i++) exp_bytes.push_back(8'h20 + 8'(i));
    exp_bytes.push_back(8'h77);
    drain(5, "simul_b");
    n_tests++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL simul_empty got %0h want 1", bus.EMPTY); end
  endtask

  task automatic test_timeout();
    int waited;
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    bus.READY = 1'b1;
    tick(); tick();
    bus.WR = 1'b1; bus.WD = 8'hA1;
    tick();
    bus.WD = 8'hA2;
    tick();
    bus.WR = 1'b0;
    waited = 0;
    while (bus.START !== 1'b1 && waited < 10) begin tick(); waited++; end
    n_tests++; if (bus.START !== 1'b1 || bus.DATA !== 8'hA1) begin n_fail++; $display("FAIL tmo_first_launch got START=%0h DATA=%0h want 1/a1", bus.START, bus.DATA); end
    for (int c = 0; c < 1023; c++) tick();
    n_tests++; if (bus.TOERR !== 1'b0) begin n_fail++; $display("FAIL tmo_early got %0h want 0", bus.TOERR); end
    tick();
    n_tests++; if (bus.TOERR !== 1'b1) begin n_fail++; $display("FAIL tmo_set got %0h want 1", bus.TOERR); end
    tick();
    n_tests++; if (bus.START !== 1'b1 || bus.DATA !== 8'hA2) begin n_fail++; $display("FAIL tmo_next_launch got START=%0h DATA=%0h want 1/a2", bus.START, bus.DATA); end
    bus.CLR_ERR = 1'b1;
    tick();
    bus.CLR_ERR = 1'b0;
    n_tests++; if (bus.TOERR !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got %0h want 0", bus.TOERR); end
    bus.READY = 1'b0;
    tick(); tick();
    n_tests++; if (bus.COUNT !== 5'd0) begin n_fail++; $display("FAIL tmo_count got %0d want 0", bus.COUNT); end
  endtask

  task automatic test_reset_mid();
    int extra;
    bus.READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.WR = 1'b1; bus.WD = 8'hB1 + 8'(i);
      tick();
    end
    bus.WR = 1'b0;
    n_tests++; if (bus.COUNT !== 5'd3) begin n_fail++; $display("FAIL rstmid_count3 got %0d want 3", bus.COUNT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (bus.COUNT !== 5'd0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", bus.COUNT); end
    n_tests++; if (bus.EMPTY !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %0h want 1", bus.EMPTY); end
    bus.READY = 1'b1;
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.START === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL rstmid_start got %0d pulses want 0", extra); end
    bus.WR = 1'b1; bus.WD = 8'hC5;
    tick();
    bus.WR = 1'b0;
    tick();
    n_tests++; if (bus.START !== 1'b1 || bus.DATA !== 8'hC5) begin n_fail++; $display("FAIL rstmid_relaunch got START=%0h DATA=%0h want 1/c5", bus.START, bus.DATA); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
